// File: rtl/tableau_dealer_if.sv
// Card stream and column-write bus between the tableau dealer and its neighbours.
//   card_in/card_valid/card_ready : shuffled deck stream into the dealer
//   wr_en/wr_col/wr_idx/wr_card   : one registered write per dealt card
// slave  = dealer side, master = deck source / tableau memory side.
interface tableau_dealer_if #(
  parameter int unsigned CARD_W = 7,
  parameter int unsigned COL_W  = 3,
  parameter int unsigned IDX_W  = 6
);
  logic [CARD_W-1:0] card_in;
  logic              card_valid;
  logic              card_ready;
  logic              wr_en;
  logic [COL_W-1:0]  wr_col;
  logic [IDX_W-1:0]  wr_idx;
  logic [CARD_W-1:0] wr_card;

  modport master (
    output card_in, card_valid,
    input  card_ready, wr_en, wr_col, wr_idx, wr_card
  );

  modport slave (
    input  card_in, card_valid,
    output card_ready, wr_en, wr_col, wr_idx, wr_card
  );
endinterface

// File: rtl/tableau_dealer.sv
// Solitaire dealing engine: consumes a shuffled deck and writes each card into
// a tableau column or the stock, stamping the visibility bit (bit 0).
//   clk, rst (sync, active-high)
//   start         : one-cycle pulse, begins a deal from IDLE or DONE
//   bus           : card stream in, column writes out (tableau_dealer_if.slave)
//   dealt_count   : cards accepted in the current deal
//   covered_count : face-down tableau cards written so far
//   busy, done    : deal in progress / deal complete
module tableau_dealer #(
  parameter int unsigned NUM_COLS  = 7,
  parameter int unsigned DECK_SIZE = 52,
  parameter int unsigned CARD_W    = 7,
  parameter bit          ROW_MAJOR = 1'b1,
  localparam int unsigned COL_W    = $clog2(NUM_COLS + 1),
  localparam int unsigned IDX_W    = (DECK_SIZE > 1) ? $clog2(DECK_SIZE) : 1,
  localparam int unsigned CNT_W    = $clog2(DECK_SIZE + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  tableau_dealer_if.slave  bus,
  output logic [CNT_W-1:0] dealt_count,
  output logic [CNT_W-1:0] covered_count,
  output logic             busy,
  output logic             done
);

  localparam int unsigned TAB_N = NUM_COLS * (NUM_COLS + 1) / 2;

  if (TAB_N > DECK_SIZE) begin : g_bad_cfg
    $error("tableau_dealer: NUM_COLS*(NUM_COLS+1)/2 exceeds DECK_SIZE");
  end

  typedef enum logic [1:0] {IDLE, DEAL_TAB, DEAL_STOCK, DONE} state_t;

  state_t            state, state_nx;
  // row is the position within a column, col the column, in both deal orders
  logic [COL_W-1:0]  row, row_nx, col, col_nx;
  logic [CNT_W-1:0]  dealt_nx, covered_nx;
  logic              busy_nx, done_nx;
  logic              wr_en_q, wr_en_nx;
  logic [COL_W-1:0]  wr_col_q, wr_col_nx;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_nx;
  logic [CARD_W-1:0] wr_card_q, wr_card_nx;
  logic              xfer, face_up, last_tab, last_card;
  logic              unused_vis;

  assign unused_vis     = bus.card_in[0];
  assign bus.card_ready = busy;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_col     = wr_col_q;
  assign bus.wr_idx     = wr_idx_q;
  assign bus.wr_card    = wr_card_q;

  // Next-state, placement and counter logic
  always_comb begin
    state_nx   = state;
    row_nx     = row;
    col_nx     = col;
    dealt_nx   = dealt_count;
    covered_nx = covered_count;
    wr_en_nx   = 1'b0;
    wr_col_nx  = wr_col_q;
    wr_idx_nx  = wr_idx_q;
    wr_card_nx = wr_card_q;

    xfer      = bus.card_valid && busy;
    // top card of a column: row==col holds for both deal orders
    face_up   = (row == col);
    last_tab  = (dealt_count == CNT_W'(TAB_N - 1));
    last_card = (dealt_count == CNT_W'(DECK_SIZE - 1));

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx   = DEAL_TAB;
          row_nx     = '0;
          col_nx     = '0;
          dealt_nx   = '0;
          covered_nx = '0;
        end
      end
      DEAL_TAB: begin
        if (xfer) begin
          wr_en_nx   = 1'b1;
          wr_col_nx  = col;
          wr_idx_nx  = IDX_W'(row);
          wr_card_nx = {bus.card_in[CARD_W-1:1], face_up};
          dealt_nx   = dealt_count + 1'b1;
          if (!face_up) covered_nx = covered_count + 1'b1;
          if (ROW_MAJOR) begin
            // next row starts on the diagonal
            if (col == COL_W'(NUM_COLS - 1)) begin
              row_nx = row + 1'b1;
              col_nx = row + 1'b1;
            end else begin
              col_nx = col + 1'b1;
            end
          end else begin
            if (row == col) begin
              col_nx = col + 1'b1;
              row_nx = '0;
            end else begin
              row_nx = row + 1'b1;
            end
          end
          if (last_tab) state_nx = (TAB_N == DECK_SIZE) ? DONE : DEAL_STOCK;
        end
      end
      DEAL_STOCK: begin
        if (xfer) begin
          wr_en_nx   = 1'b1;
          wr_col_nx  = COL_W'(NUM_COLS);
          wr_idx_nx  = IDX_W'(dealt_count - CNT_W'(TAB_N));
          wr_card_nx = {bus.card_in[CARD_W-1:1], 1'b0};
          dealt_nx   = dealt_count + 1'b1;
          if (last_card) state_nx = DONE;
        end
      end
      default: state_nx = IDLE;
    endcase

    busy_nx = (state_nx == DEAL_TAB) || (state_nx == DEAL_STOCK);
    done_nx = (state_nx == DONE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      row           <= '0;
      col           <= '0;
      dealt_count   <= '0;
      covered_count <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_col_q      <= '0;
      wr_idx_q      <= '0;
      wr_card_q     <= '0;
    end else begin
      state         <= state_nx;
      row           <= row_nx;
      col           <= col_nx;
      dealt_count   <= dealt_nx;
      covered_count <= covered_nx;
      busy          <= busy_nx;
      done          <= done_nx;
      wr_en_q       <= wr_en_nx;
      wr_col_q      <= wr_col_nx;
      wr_idx_q      <= wr_idx_nx;
      wr_card_q     <= wr_card_nx;
    end
  end

endmodule
